logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit; successor to the fixed 64-bit combinational XOR.
- Operand width and pipeline depth are parameters. Operation is selected per transaction: XOR, OR, AND, XNOR.
- Valid/ready handshakes on input and output, with full backpressure.
- Sits in the integer execute path of the RV64F core, between the issue stage and writeback arbitration.

---
 rtl/logic_pkg.sv | 12 +
 rtl/logic_pipe_stage.sv | 33 +++
 rtl/logic_unit_pipe.sv | 78 +++++++
 tb/tb_logic_unit_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared encodings for the pipelined bitwise logic unit.
// Imported by logic_pipe_stage and logic_unit_pipe.
package logic_pkg;

    localparam logic [1:0] LOP_XOR  = 2'b00;
    localparam logic [1:0] LOP_OR   = 2'b01;
    localparam logic [1:0] LOP_AND  = 2'b10;
    localparam logic [1:0] LOP_XNOR = 2'b11;

    localparam int TAG_W = 5;

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/payload register of the logic unit pipeline.
// Advances when empty or when the downstream stage advances.
module logic_pipe_stage
    import logic_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          down_adv,
    output logic          adv,
    output logic          valid,
    output logic [PW-1:0] data
);

    assign adv = !valid || down_adv;

    // Payload only loads behind a valid beat, so bubbles leave it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise XOR/OR/AND/XNOR unit with valid/ready on both sides.
// Optional LOGIC_UNIT_ZERO_FLAG_EN adds a pipelined out_zero flag.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic [WIDTH-1:0] out_s,
    output logic [TAG_W-1:0] out_tag
);

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    localparam int PW = WIDTH + TAG_W + 1;
`else
    localparam int PW = WIDTH + TAG_W;
`endif

    logic [WIDTH-1:0] res;
    logic             v_q   [0:STAGES];
    logic [PW-1:0]    d_q   [0:STAGES];
    logic             adv_q [1:STAGES+1];

    always_comb begin
        res = '0;
        unique case (in_op)
            LOP_XOR:  res = in_a ^ in_b;
            LOP_OR:   res = in_a | in_b;
            LOP_AND:  res = in_a & in_b;
            LOP_XNOR: res = ~(in_a ^ in_b);
        endcase
    end

    assign v_q[0] = in_valid;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    assign d_q[0] = {~|res, in_tag, res};
`else
    assign d_q[0] = {in_tag, res};
`endif
    assign adv_q[STAGES+1] = out_ready;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic_pipe_stage #(
            .PW(PW)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_valid(v_q[k-1]),
            .up_data (d_q[k-1]),
            .down_adv(adv_q[k+1]),
            .adv     (adv_q[k]),
            .valid   (v_q[k]),
            .data    (d_q[k])
        );
    end

    assign in_ready  = adv_q[1];
    assign out_valid = v_q[STAGES];
    assign out_s     = d_q[STAGES][WIDTH-1:0];
    assign out_tag   = d_q[STAGES][WIDTH +: TAG_W];
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    assign out_zero  = d_q[STAGES][PW-1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe plus STAGES=4 and WIDTH=1 corners.
// Zero-flag checks compile in when LOGIC_UNIT_ZERO_FLAG_EN is defined.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    localparam int W  = 64;
    localparam int ST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_a, in_b, out_s;
    logic [1:0]   in_op;
    logic [4:0]   in_tag, out_tag;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_a, b_in_b, b_out_s;
    logic [1:0]   b_in_op;
    logic [4:0]   b_in_tag, b_out_tag;

    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [0:0]   c_in_a, c_in_b, c_out_s;
    logic [1:0]   c_in_op;
    logic [4:0]   c_in_tag, c_out_tag;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic out_zero, b_out_zero, c_out_zero;
`endif

    logic_unit_pipe #(.WIDTH(W), .STAGES(ST)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        .out_zero(out_zero),
`endif
        .out_s(out_s), .out_tag(out_tag)
    );

    logic_unit_pipe #(.WIDTH(W), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        .out_zero(b_out_zero),
`endif
        .out_s(b_out_s), .out_tag(b_out_tag)
    );

    logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(c_in_a), .in_b(c_in_b), .in_op(c_in_op), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        .out_zero(c_out_zero),
`endif
        .out_s(c_out_s), .out_tag(c_out_tag)
    );

    typedef struct {
        logic [W-1:0] s;
        logic [4:0]   t;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   lat_on = 1'b0;
    bit   acc;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [W-1:0] x;
        x = (a | b) & ~(a & b);
        case (op)
            2'd0:    return x;
            2'd1:    return ~(~a & ~b);
            2'd2:    return ~(~a | ~b);
            default: return ~x;
        endcase
    endfunction

    // Samples both handshakes mid-cycle, then advances one clock.
    task automatic tick();
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out_s", out_s, e.s);
                check("out_tag", out_tag, e.t);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
                check("out_zero", out_zero, e.z);
`endif
                if (lat_on) check("latency", cyc - e.cyc, ST);
            end
        end
        if (acc) begin
            e.s   = ref_op(in_op, in_a, in_b);
            e.t   = in_tag;
            e.z   = (e.s == '0);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] t);
        int n;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = t;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 30 && sb.size() > 0; i++) tick();
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        logic [W-1:0] bexp [1:4];
        rst_n = 1'b0;
        in_valid = 0; out_ready = 1; in_a = 0; in_b = 0; in_op = 0; in_tag = 0;
        b_in_valid = 0; b_out_ready = 1; b_in_a = 0; b_in_b = 0;
        b_in_op = 0; b_in_tag = 0;
        c_in_valid = 0; c_out_ready = 1; c_in_a = 0; c_in_b = 0;
        c_in_op = 0; c_in_tag = 0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_s", out_s, '0);
        check("rst_out_tag", out_tag, '0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        lat_on = 1'b1;
        send(LOP_XOR, 64'hF0, 64'h3C, 5'd7);
        send(LOP_XNOR, 64'hF0, 64'h3C, 5'd8);
        for (int op = 0; op < 4; op++)
            for (int i = 0; i < 256; i += 17)
                for (int j = 0; j < 256; j += 15)
                    send(op[1:0], W'(i), W'(j), 5'((i + j + op) & 31));
        for (int k = 0; k < 40; k++)
            send(2'($urandom_range(3)), {$urandom, $urandom},
                 {$urandom, $urandom}, 5'($urandom_range(31)));
        drain();
        lat_on = 1'b0;

        // Backpressure: third push refused while stalled.
        out_ready = 1'b0;
        send(LOP_OR, 64'h11, 64'h22, 5'd1);
        send(LOP_AND, 64'hFF, 64'h0F, 5'd2);
        in_valid = 1'b1; in_op = LOP_XOR; in_a = 64'h5; in_b = 64'h3;
        in_tag = 5'd3;
        #1;
        check("bp_in_ready", in_ready, 1'b0);
        tick();
        tick();
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_tag", out_tag, 5'd1);
        out_ready = 1'b1;
        send(LOP_XOR, 64'h5, 64'h3, 5'd3);
        drain();

        // Full pipe with simultaneous accept and emit.
        out_ready = 1'b0;
        send(LOP_XOR, 64'hA, 64'h6, 5'd10);
        send(LOP_OR, 64'hA, 64'h6, 5'd11);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_op = 2'($urandom_range(3));
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            in_tag = 5'(k + 12);
            #1;
            check("sim_in_ready", in_ready, 1'b1);
            check("sim_out_valid", out_valid, 1'b1);
            tick();
        end
        drain();

        // Reset with two results in flight.
        out_ready = 1'b0;
        send(LOP_AND, 64'hFFFF, 64'h1234, 5'd20);
        send(LOP_XNOR, 64'h0, 64'h0, 5'd21);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_s", out_s, '0);
        check("mid_rst_tag", out_tag, '0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        sb.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_op = 2'($urandom_range(3));
            in_a = {$urandom, $urandom};
            tick();
        end
        check("post_rst_valid", out_valid, 1'b0);
        send(LOP_OR, 64'h0, 64'h0, 5'd22);
        drain();

        // Bubble collapse on the 4-stage instance.
        b_out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            b_in_valid = 1'b1;
            b_in_op = LOP_XOR;
            b_in_a = {$urandom, $urandom};
            b_in_b = 64'(k);
            b_in_tag = 5'(k);
            bexp[k] = ref_op(LOP_XOR, b_in_a, b_in_b);
            #1;
            check("bub_in_ready", b_in_ready, 1'b1);
            tick();
            b_in_valid = 1'b0;
            if (k == 1) begin
                tick();
                tick();
            end
        end
        check("bub_full_ready", b_in_ready, 1'b0);
        check("bub_full_valid", b_out_valid, 1'b1);
        check("bub_full_tag", b_out_tag, 5'd1);
        b_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("bub_out_valid", b_out_valid, 1'b1);
            check("bub_out_tag", b_out_tag, 5'(k));
            check("bub_out_s", b_out_s, bexp[k]);
            tick();
        end
        check("bub_empty", b_out_valid, 1'b0);

        // WIDTH=1 corner.
        c_in_valid = 1'b1; c_in_op = LOP_AND; c_in_a = 1'b0; c_in_b = 1'b1;
        c_in_tag = 5'd4;
        tick();
        c_in_valid = 1'b0;
        check("w1_and_valid", c_out_valid, 1'b1);
        check("w1_and_s", c_out_s, 1'b0);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("w1_and_zero", c_out_zero, 1'b1);
`endif
        c_in_valid = 1'b1; c_in_op = LOP_OR;
        tick();
        c_in_valid = 1'b0;
        check("w1_or_s", c_out_s, 1'b1);
        check("w1_or_tag", c_out_tag, 5'd4);
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        check("w1_or_zero", c_out_zero, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
